// File: rtl/vga_display_driver.sv
// VGA raster generator and output stage: counts pixels/lines, derives sync/blank,
// delays timing to match the object-mux latency and registers the DAC pins.
module vga_display_driver #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_ACTIVE = 0,
    parameter int MUX_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  redIn,
    input  logic [7:0]  greenIn,
    input  logic [7:0]  blueIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        visible,
    output logic        startOfFrame,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_MAX    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_MAX    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE != 0);
    localparam logic SYNC_OFF = ~SYNC_ON;

    // Timing word layout: {hs, vs, blank}; IDLE is what a flushed pipeline emits.
    localparam logic [2:0] TIM_IDLE = {SYNC_OFF, SYNC_OFF, 1'b1};

    function automatic logic [7:0] gate_colour(input logic [7:0] c, input logic blank);
        return blank ? 8'h00 : c;
    endfunction

    logic [10:0] h_p0, v_p0;
    logic [10:0] h_next, v_next;
    logic        visible_p0, sof_p0;

    always_comb begin
        h_next = h_p0 + 11'd1;
        v_next = v_p0;
        if (h_p0 == H_MAX) begin
            h_next = 11'd0;
            v_next = (v_p0 == V_MAX) ? 11'd0 : v_p0 + 11'd1;
        end
    end

    // ---- stage p0: raster counters and the flags describing them
    always_ff @(posedge clk) begin
        if (reset) begin
            h_p0       <= 11'd0;
            v_p0       <= 11'd0;
            visible_p0 <= 1'b1;
            // Primed so the first cycle out of reset, already at (0,0), reports frame start.
            sof_p0     <= 1'b1;
        end else begin
            h_p0       <= h_next;
            v_p0       <= v_next;
            visible_p0 <= (h_next < H_VIS) && (v_next < V_VIS);
            sof_p0     <= (h_next == 11'd0) && (v_next == 11'd0);
        end
    end

    assign pixelX       = h_p0;
    assign pixelY       = v_p0;
    assign visible      = visible_p0;
    assign startOfFrame = sof_p0 & ~reset;

    logic       hs_raw, vs_raw, blank_raw;
    logic [2:0] tim_raw, tim_dly;

    assign hs_raw    = (h_p0 >= HS_START && h_p0 < HS_END) ? SYNC_ON : SYNC_OFF;
    assign vs_raw    = (v_p0 >= VS_START && v_p0 < VS_END) ? SYNC_ON : SYNC_OFF;
    assign blank_raw = ~visible_p0;
    assign tim_raw   = {hs_raw, vs_raw, blank_raw};

    // ---- stage p1: timing delay line matching the object-mux latency
    generate
        if (MUX_LATENCY == 0) begin : g_no_delay
            assign tim_dly = tim_raw;
        end else begin : g_delay
            logic [2:0] dly_p1 [MUX_LATENCY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < MUX_LATENCY; i++) dly_p1[i] <= TIM_IDLE;
                end else begin
                    dly_p1[0] <= tim_raw;
                    for (int i = 1; i < MUX_LATENCY; i++) dly_p1[i] <= dly_p1[i-1];
                end
            end

            assign tim_dly = dly_p1[MUX_LATENCY-1];
        end
    endgenerate

    // ---- stage p2: output register, colour and timing leave aligned
    logic [7:0] r_p2, g_p2, b_p2;
    logic       hs_p2, vs_p2, blank_n_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p2       <= 8'h00;
            g_p2       <= 8'h00;
            b_p2       <= 8'h00;
            hs_p2      <= SYNC_OFF;
            vs_p2      <= SYNC_OFF;
            blank_n_p2 <= 1'b0;
        end else begin
            r_p2       <= gate_colour(redIn,   tim_dly[0]);
            g_p2       <= gate_colour(greenIn, tim_dly[0]);
            b_p2       <= gate_colour(blueIn,  tim_dly[0]);
            hs_p2      <= tim_dly[2];
            vs_p2      <= tim_dly[1];
            blank_n_p2 <= ~tim_dly[0];
        end
    end

    assign VGA_R       = r_p2;
    assign VGA_G       = g_p2;
    assign VGA_B       = b_p2;
    assign VGA_HS      = hs_p2;
    assign VGA_VS      = vs_p2;
    assign VGA_BLANK_N = blank_n_p2;

endmodule
